// File: rtl/nrisc_pkg.sv
// Shared constants and types for the nrisc instruction-fetch path.
package nrisc_pkg;

    localparam int unsigned NRISC_AW = 8;
    localparam int unsigned NRISC_DW = 8;

    // Fetch engine state: nothing outstanding, live request, or stale request.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with synchronous flush and an occupancy count.
module fifo_sync #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // Guard against popping empty or pushing full; a pop frees room for a push.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    // Storage, pointers and count; flush only resets bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one outstanding memory read, results queued for the core.
module instr_prefetch
    import nrisc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = NRISC_AW,
    parameter int unsigned DW    = NRISC_DW
) (
    input  logic                   Clock,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_addr,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    input  logic                   mem_ack,
    input  logic [DW-1:0]          mem_data,
    output logic                   inst_valid,
    output logic [DW-1:0]          inst_data,
    output logic [AW-1:0]          inst_pc,
    input  logic                   inst_ready,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e     r_state;
    logic [AW-1:0]    r_fetch_pc;
    logic             r_mem_req;
    logic [AW-1:0]    r_mem_addr;

    logic             w_pop;
    logic             w_push;
    logic [CW-1:0]    w_occ_after_push;
    logic [AW-1:0]    w_pc_inc;
    logic [AW+DW-1:0] w_head;

    // A redirect flushes the queue, so any same-cycle pop or push is void.
    assign w_pop            = inst_valid && inst_ready && !redirect;
    assign w_push           = (r_state == REQ) && mem_ack && !redirect;
    assign w_occ_after_push = occupancy + CW'(1) - CW'(w_pop);
    assign w_pc_inc         = r_fetch_pc + AW'(1);

    fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (AW + DW)
    ) u_fifo (
        .i_clk   (Clock),
        .i_rst_n (reset),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_data  ({r_fetch_pc, mem_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (occupancy)
    );

    // Fetch FSM; mem_req/mem_addr are registered and held for the whole request.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_addr;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= redirect_addr;
                        r_state    <= REQ;
                    end else if (occupancy < CW'(DEPTH)) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_addr;
                        if (mem_ack) begin
                            r_mem_addr <= redirect_addr;
                        end else begin
                            // Request still in flight: wait for its ack, then drop it.
                            r_state <= DISCARD;
                        end
                    end else if (mem_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_occ_after_push < CW'(DEPTH)) begin
                            r_mem_addr <= w_pc_inc;
                        end else begin
                            r_mem_req <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    // fetch_pc holds the latest redirect target while the stale ack is pending.
                    if (redirect) begin
                        r_fetch_pc <= redirect_addr;
                    end
                    if (mem_ack) begin
                        r_mem_addr <= redirect ? redirect_addr : r_fetch_pc;
                        r_state    <= REQ;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign inst_valid = (occupancy != '0);
    assign inst_pc    = w_head[AW+DW-1:DW];
    assign inst_data  = w_head[DW-1:0];

endmodule
